// File: rtl/bus_slot_scheduler_if.sv
// Bus-slot scheduler signal bundle.
// The master modport is the scheduler itself (it receives CPU/video/host
// status and drives grants and timing). The slave modport is the bus mux /
// requester side (it drives the status lines and observes the grants).
interface bus_slot_scheduler_if #(
  parameter int SLOT_COUNT = 8
);
  logic                          cpu_ready_i;
  logic                          col_80_i;
  logic                          wb_req_i;
  logic [1:0]                    video_grant_o;
  logic                          wb_grant_o;
  logic                          wb_done_o;
  logic                          cpu_be_o;
  logic                          cpu_phi2_o;
  logic                          slot_strobe_o;
  logic [$clog2(SLOT_COUNT)-1:0] slot_o;

  modport master (
    input  cpu_ready_i, col_80_i, wb_req_i,
    output video_grant_o, wb_grant_o, wb_done_o,
    output cpu_be_o, cpu_phi2_o, slot_strobe_o, slot_o
  );

  modport slave (
    output cpu_ready_i, col_80_i, wb_req_i,
    input  video_grant_o, wb_grant_o, wb_done_o,
    input  cpu_be_o, cpu_phi2_o, slot_strobe_o, slot_o
  );
endinterface

// File: rtl/bus_slot_scheduler.sv
// Time-division scheduler for the shared SRAM/Wishbone bus.
// One CPU cycle (frame) is split into SLOT_COUNT slots of SLOT_CYCLES clocks:
//   slot 0        video char fetch
//   slot 1        video glyph fetch when 80-col mode, otherwise host-eligible
//   slots 2..N/2-1 host (Wishbone) eligible
//   upper half    6502 bus (phi2 high) when the CPU cycle is issued
// Optional build macro CPU_STALL_TO_WB_EN: when the CPU cycle is not issued,
// the upper-half slots become host-eligible instead of idling.
module bus_slot_scheduler #(
  parameter int CYCLES_PER_FRAME = 64,
  parameter int SLOT_CYCLES      = 8,
  parameter int SLOT_COUNT       = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  bus_slot_scheduler_if.master  bus
);

  localparam int CNT_W  = $clog2(CYCLES_PER_FRAME);
  localparam int OFF_W  = $clog2(SLOT_CYCLES);
  localparam int SLOT_W = $clog2(SLOT_COUNT);
  localparam logic [SLOT_W-1:0] CPU_FIRST = SLOT_W'(SLOT_COUNT / 2);
  localparam logic [SLOT_W-1:0] GLYPH_SLOT = SLOT_W'(1);

  logic [CNT_W-1:0]  cnt;
  logic              run;
  logic              col80_q;
  logic              issue_q;
  logic              wb_grant_q;

  logic [SLOT_W-1:0] slot;
  logic [OFF_W-1:0]  off;
  logic              strobe;
  logic              last;
  logic              cpu_slot;
  logic              issue_pt;
  logic              issue;
  logic              wb_elig;
  logic              wb_grant;

  // run stays low for the first edge after reset so that clock 0 of the
  // first frame is a full cycle with strobe and video grant visible.
  assign slot     = cnt[CNT_W-1:OFF_W];
  assign off      = cnt[OFF_W-1:0];
  assign strobe   = run && (off == '0);
  assign last     = run && (off == '1);
  assign cpu_slot = (slot >= CPU_FIRST);
  assign issue_pt = strobe && (slot == CPU_FIRST);

  // On the issue clock the ready bit is used live so phi2 covers all of slot
  // 4; for the rest of the CPU half the captured decision is held.
  assign issue = issue_pt ? bus.cpu_ready_i : issue_q;

  // Which slots may be handed to the Wishbone host this frame.
  always_comb begin
    wb_elig = 1'b0;
    if (slot == GLYPH_SLOT) begin
      wb_elig = !col80_q;
    end else if ((slot != '0) && !cpu_slot) begin
      wb_elig = 1'b1;
`ifdef CPU_STALL_TO_WB_EN
    end else if (cpu_slot) begin
      wb_elig = !issue;
`endif
    end
  end

  // Grant decision is made on the strobe clock and then held by wb_grant_q,
  // so a requester dropping wb_req_i mid-slot cannot truncate the transfer.
  assign wb_grant = strobe ? (wb_elig && bus.wb_req_i) : (run && wb_grant_q);

  // Frame counter; wraps naturally because the frame length is a power of 2.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run <= 1'b0;
      cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Per-frame decisions: 80-col mode, CPU issue, and the held host grant.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      col80_q    <= 1'b0;
      issue_q    <= 1'b0;
      wb_grant_q <= 1'b0;
    end else begin
      if (strobe && (slot == '0)) begin
        col80_q <= bus.col_80_i;
      end
      if (issue_pt) begin
        issue_q <= bus.cpu_ready_i;
      end else if (run && (cnt == '1)) begin
        issue_q <= 1'b0;
      end
      if (strobe) begin
        wb_grant_q <= wb_elig && bus.wb_req_i;
      end else if (last) begin
        wb_grant_q <= 1'b0;
      end
    end
  end

  assign bus.video_grant_o[0] = run && (slot == '0);
  assign bus.video_grant_o[1] = run && (slot == GLYPH_SLOT) && col80_q;
  assign bus.wb_grant_o       = wb_grant;
  assign bus.wb_done_o        = wb_grant && last;
  assign bus.cpu_be_o         = run && cpu_slot && issue;
  assign bus.cpu_phi2_o       = run && cpu_slot && issue;
  assign bus.slot_strobe_o    = strobe;
  assign bus.slot_o           = slot;

endmodule

// File: tb/tb_bus_slot_scheduler.sv
// Scoreboard bench for bus_slot_scheduler: directed frames push per-slot
// expectations into a queue; a monitor pops one record per slot strobe and
// checks grants every clock of that slot. A short random phase then checks
// exclusivity of grants and that every wb_done_o closes a held grant.
module tb_bus_slot_scheduler;

  logic clk;
  logic rst_n;

  bus_slot_scheduler_if #(.SLOT_COUNT(8)) bus ();

  bus_slot_scheduler #(
    .CYCLES_PER_FRAME(64),
    .SLOT_CYCLES(8),
    .SLOT_COUNT(8)
  ) dut (
    .clock_i  (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CPU_STALL_TO_WB_EN
  localparam bit [7:0] STALL_WB = 8'hF0;
`else
  localparam bit [7:0] STALL_WB = 8'h00;
`endif

  typedef struct {
    bit       col80;
    bit       col80_mid;
    bit       ready;
    bit       req;
    bit       req_mid;
    bit [7:0] exp_wb;
    bit       exp_v1;
    bit       exp_cpu;
  } vec_t;

  typedef struct packed {
    logic [2:0] slot;
    logic [1:0] vid;
    logic       wb;
    logic       cpu;
    logic       done;
  } exp_t;

  vec_t vecs[9];
  exp_t q[$];

  int ntests = 0;
  int nfail  = 0;

  bit   sb_on  = 1'b0;
  bit   rnd_on = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;
  int   idx = 0;
  bit   g_hold = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one record per slot, checked on every clock.
  always @(negedge clk) begin
    if (!rst_n || !sb_on) begin
      have_cur = 1'b0;
    end else begin
      if (bus.slot_strobe_o) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
          have_cur = 1'b0;
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          idx = 0;
          check("slot_index", bus.slot_o, cur.slot);
        end
      end else if (have_cur) begin
        idx++;
      end
      if (have_cur) begin
        check("video_grant", bus.video_grant_o, cur.vid);
        check("wb_grant", bus.wb_grant_o, cur.wb);
        check("cpu_be", bus.cpu_be_o, cur.cpu);
        check("cpu_phi2", bus.cpu_phi2_o, cur.cpu);
        check("wb_done", bus.wb_done_o, (cur.done && idx == 7) ? 1 : 0);
      end else begin
        check("wb_done_idle", bus.wb_done_o, 0);
      end
    end
  end

  // Random-phase property checker.
  always @(negedge clk) begin
    if (rnd_on && rst_n) begin
      check("grant_exclusive",
            ($countones({bus.video_grant_o, bus.wb_grant_o, bus.cpu_be_o}) <= 1) ? 1 : 0, 1);
      check("phi2_matches_be", bus.cpu_phi2_o, bus.cpu_be_o);
      if (bus.slot_strobe_o) g_hold = bus.wb_grant_o;
      else                   g_hold = g_hold && bus.wb_grant_o;
      if (bus.wb_done_o) check("done_after_grant", g_hold, 1);
    end
  end

  task automatic push_slots(input vec_t v, input int nslots);
    for (int s = 0; s < nslots; s++) begin
      exp_t e;
      e.slot = s[2:0];
      e.vid  = (s == 0) ? 2'b01 : ((s == 1 && v.exp_v1) ? 2'b10 : 2'b00);
      e.wb   = v.exp_wb[s];
      e.cpu  = (s >= 4) && v.exp_cpu;
      e.done = v.exp_wb[s];
      q.push_back(e);
    end
  endtask

  // Entered 1 time unit after the edge that starts frame clock 0; returns at
  // the same point of the following frame.
  task automatic do_frame(input vec_t v);
    push_slots(v, 8);
    bus.col_80_i    = v.col80;
    bus.cpu_ready_i = v.ready;
    bus.wb_req_i    = v.req;
    repeat (20) @(posedge clk);
    #1;
    bus.col_80_i = v.col80_mid;
    bus.wb_req_i = v.req_mid;
    repeat (44) @(posedge clk);
    #1;
  endtask

  initial begin
    bit d;
    //            col80 mid  rdy  req  mid  exp_wb           v1   cpu
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,           1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0E,           1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0E,           1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0C,           1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00,           1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0E | STALL_WB, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,           1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h06,           1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,           1'b0, 1'b1};

    rst_n = 1'b0;
    bus.col_80_i    = 1'b0;
    bus.cpu_ready_i = 1'b0;
    bus.wb_req_i    = 1'b0;

    // Outputs held low during reset.
    repeat (3) @(negedge clk);
    check("rst_video_grant", bus.video_grant_o, 0);
    check("rst_wb_grant", bus.wb_grant_o, 0);
    check("rst_wb_done", bus.wb_done_o, 0);
    check("rst_cpu_be", bus.cpu_be_o, 0);
    check("rst_cpu_phi2", bus.cpu_phi2_o, 0);
    check("rst_strobe", bus.slot_strobe_o, 0);
    check("rst_slot", bus.slot_o, 0);

    rst_n = 1'b1;
    sb_on = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) do_frame(vecs[i]);

    // Reset asserted at clock 12, in the middle of a granted host slot.
    push_slots('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1}, 2);
    bus.col_80_i    = 1'b0;
    bus.cpu_ready_i = 1'b1;
    bus.wb_req_i    = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_wb_grant", bus.wb_grant_o, 0);
    check("abort_wb_done", bus.wb_done_o, 0);
    check("abort_video", bus.video_grant_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold_done", bus.wb_done_o, 0);
      check("abort_hold_grant", bus.wb_grant_o, 0);
    end
    bus.wb_req_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_frame(vecs[7]);
    do_frame(vecs[8]);
    sb_on = 1'b0;
    check("scoreboard_drained", q.size(), 0);

    // Random requester: holds a request until its done pulse.
    rnd_on = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      d = bus.wb_done_o;
      @(posedge clk);
      #1;
      if (bus.wb_req_i && d)  bus.wb_req_i = ($urandom_range(0, 1) == 1);
      else if (!bus.wb_req_i) bus.wb_req_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) bus.col_80_i    = ~bus.col_80_i;
      if ($urandom_range(0, 15) == 0) bus.cpu_ready_i = ~bus.cpu_ready_i;
    end
    rnd_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
